jk_cmd_queue: RTL

Command buffer and sequencer that sits directly upstream of the JK flip-flop stage. It accepts set/reset/toggle/hold commands, each with a repeat count, over a valid/ready handshake and queues them in a small FIFO. It drives registered `j`/`k` levels into the flip-flop, one command at a time, for the requested number of cycles. An optional shadow model tracks the flip-flop's expected `q` and flags any divergence.

---
 rtl/jk_cmd_pkg.sv | 41 ++++
 rtl/jk_cmd_fifo.sv | 63 ++++++
 rtl/jk_cmd_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/jk_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jk_cmd_pkg
// Brief    : Shared command types and JK next-state helper for jk_cmd_queue.
// Revision : 1.0 - initial release
// ============================================================================
package jk_cmd_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } jk_cmd_e;

  localparam int JK_CNT_W = 4;

  typedef struct packed {
    jk_cmd_e               jk;
    logic [JK_CNT_W-1:0]   cnt;
  } jk_cmd_t;

  typedef enum logic [0:0] {
    SLOT_IDLE  = 1'b0,
    SLOT_ISSUE = 1'b1
  } slot_state_e;

  function automatic logic jk_next(input logic [1:0] jk, input logic q);
    logic r;
    r = q;
    case (jk)
      2'b01:   r = 1'b0;
      2'b10:   r = 1'b1;
      2'b11:   r = ~q;
      default: r = q;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jk_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : jk_cmd_fifo
// Brief    : Synchronous command FIFO; occupancy counter separates full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module jk_cmd_fifo
  import jk_cmd_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = jk_cmd_t
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  T                           i_data,
  input  logic                       i_pop,
  output T                           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = $clog2(DEPTH+1);

  T                   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               r_full;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      // Push and pop together leave occupancy (and full) untouched.
      if (i_push && !i_pop) begin
        r_level <= r_level + 1'b1;
        r_full  <= (r_level == c_LVL_W'(DEPTH-1));
      end else if (!i_push && i_pop) begin
        r_level <= r_level - 1'b1;
        r_full  <= 1'b0;
      end
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/jk_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : jk_cmd_queue
// Brief    : Queues JK commands and drives registered j/k for cnt+1 cycles each.
//            Optional shadow q model enabled by `define JK_CMD_SHADOW_EN.
// Revision : 1.0 - initial release
// ============================================================================
module jk_cmd_queue
  import jk_cmd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [1:0]                 i_in_jk,
  input  logic [CNT_W-1:0]           i_in_cnt,
  output logic                       o_j,
  output logic                       o_k,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_level
`ifdef JK_CMD_SHADOW_EN
  ,
  input  logic                       i_q_fb,
  output logic                       o_exp_q,
  output logic                       o_mismatch
`endif
);

  typedef struct packed {
    jk_cmd_e            jk;
    logic [CNT_W-1:0]   cnt;
  } cmd_t;

  slot_state_e      r_state;
  logic [1:0]       r_jk;
  logic [CNT_W-1:0] r_remaining;

  cmd_t w_in_cmd;
  cmd_t w_head;
  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_load;
  logic w_pop;
  logic w_bypass;
  logic w_push;

  assign w_in_cmd   = '{jk: jk_cmd_e'(i_in_jk), cnt: i_in_cnt};
  assign o_in_ready = !w_full && !rst;
  assign w_accept   = i_in_valid && o_in_ready;

  // The slot may take a new command when empty or on its final cycle.
  assign w_load   = (r_state == SLOT_IDLE) || (r_remaining == '0);
  assign w_pop    = w_load && !w_empty;
  assign w_bypass = w_load && w_empty && w_accept;
  assign w_push   = w_accept && !w_bypass;

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_in_cmd),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SLOT_IDLE;
      r_jk        <= 2'b00;
      r_remaining <= '0;
    end else if (w_load) begin
      if (w_pop) begin
        r_state     <= SLOT_ISSUE;
        r_jk        <= w_head.jk;
        r_remaining <= w_head.cnt;
      end else if (w_bypass) begin
        r_state     <= SLOT_ISSUE;
        r_jk        <= w_in_cmd.jk;
        r_remaining <= w_in_cmd.cnt;
      end else begin
        r_state     <= SLOT_IDLE;
        r_jk        <= 2'b00;
        r_remaining <= '0;
      end
    end else begin
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign o_j    = r_jk[1];
  assign o_k    = r_jk[0];
  assign o_busy = (r_state == SLOT_ISSUE);

`ifdef JK_CMD_SHADOW_EN
  logic r_exp_q;
  logic r_mismatch;

  // Same edge and same registered j/k as the downstream flip-flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_exp_q    <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_exp_q    <= jk_next(r_jk, r_exp_q);
      r_mismatch <= r_mismatch | (i_q_fb != r_exp_q);
    end
  end

  assign o_exp_q    = r_exp_q;
  assign o_mismatch = r_mismatch;
`endif

endmodule
`default_nettype wire
